// File: rtl/mult_digit_seq.sv
// mult_digit_seq: WIDTH x WIDTH unsigned multiplier built by sequencing one
// shared combinational 2x2 multiplier over all digit pairs and accumulating
// the shifted 4-bit partial products (D*D cycles per product, D = WIDTH/2).
//
// Optional feature macro: MULT_DIGIT_SEQ_ZERO_SKIP_EN
//   defined   - a zero operand completes on the accepting edge (product 0,
//               done pulse, no RUN phase)
//   undefined - zero operands take the normal RUN path
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request, sampled only while idle
//   a, b           operands, captured on the accepting edge
//   busy           high while the digit sequence runs
//   done           one-cycle completion pulse
//   product        last result, held until the next completion
//   mul_a, mul_b   registered digits driven to the shared 2x2 multiplier
//   mul_y          combinational result of the shared 2x2 multiplier
module mult_digit_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           mul_a,
   output logic [1:0]           mul_b,
   input  logic [3:0]           mul_y
);

   localparam int unsigned D  = WIDTH / 2;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned XW = CW + 1;
   localparam logic [CW-1:0] LAST = CW'(D - 1);

`ifdef MULT_DIGIT_SEQ_ZERO_SKIP_EN
   localparam bit ZERO_SKIP = 1'b1;
`else
   localparam bit ZERO_SKIP = 1'b0;
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_n;
   logic [WIDTH-1:0] a_reg, a_reg_n;
   logic [WIDTH-1:0] b_reg, b_reg_n;
   logic [PW-1:0]   acc, acc_n;
   logic [CW-1:0]   i_q, i_n;
   logic [CW-1:0]   j_q, j_n;
   logic            busy_n;
   logic            done_n;
   logic [PW-1:0]   product_n;
   logic [1:0]      mul_a_n;
   logic [1:0]      mul_b_n;
   logic [XW:0]     shift_c;
   logic [PW-1:0]   sum_c;

   // Partial product weight is 4^(i+j), i.e. a shift of 2*(i+j) bits.
   assign shift_c = (XW+1)'({i_q, 1'b0}) + (XW+1)'({j_q, 1'b0});
   assign sum_c   = acc + (PW'(mul_y) << shift_c);

   // Next-state and next-output logic.
   always_comb begin
      state_n   = state;
      a_reg_n   = a_reg;
      b_reg_n   = b_reg;
      acc_n     = acc;
      i_n       = i_q;
      j_n       = j_q;
      busy_n    = busy;
      done_n    = 1'b0;
      product_n = product;
      mul_a_n   = mul_a;
      mul_b_n   = mul_b;

      case (state)
         IDLE: begin
            mul_a_n = 2'b00;
            mul_b_n = 2'b00;
            if (start) begin
               if (ZERO_SKIP && ((a == '0) || (b == '0))) begin
                  product_n = '0;
                  done_n    = 1'b1;
               end else begin
                  a_reg_n = a;
                  b_reg_n = b;
                  acc_n   = '0;
                  i_n     = '0;
                  j_n     = '0;
                  busy_n  = 1'b1;
                  state_n = RUN;
                  // First digit pair is presented in the first RUN cycle.
                  mul_a_n = a[1:0];
                  mul_b_n = b[1:0];
               end
            end
         end

         RUN: begin
            acc_n = sum_c;
            if ((i_q == LAST) && (j_q == LAST)) begin
               product_n = sum_c;
               done_n    = 1'b1;
               busy_n    = 1'b0;
               state_n   = IDLE;
               i_n       = '0;
               j_n       = '0;
               mul_a_n   = 2'b00;
               mul_b_n   = 2'b00;
            end else begin
               // j is the inner digit counter, i the outer one.
               if (j_q == LAST) begin
                  j_n = '0;
                  i_n = i_q + CW'(1);
               end else begin
                  j_n = j_q + CW'(1);
               end
               mul_a_n = a_reg[{i_n, 1'b0} +: 2];
               mul_b_n = b_reg[{j_n, 1'b0} +: 2];
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         acc     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mul_a   <= 2'b00;
         mul_b   <= 2'b00;
      end else begin
         state   <= state_n;
         a_reg   <= a_reg_n;
         b_reg   <= b_reg_n;
         acc     <= acc_n;
         i_q     <= i_n;
         j_q     <= j_n;
         busy    <= busy_n;
         done    <= done_n;
         product <= product_n;
         mul_a   <= mul_a_n;
         mul_b   <= mul_b_n;
      end
   end

endmodule

// File: tb/tb_mult_digit_seq.sv
// Testbench for mult_digit_seq (WIDTH=8): table-driven operations plus
// hand-written sequences for ignored start, back-to-back, reset abort and
// zero operands. The shared 2x2 multiplier is modelled in the bench.
module tb_mult_digit_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [1:0]  mul_a;
   logic [1:0]  mul_b;
   logic [3:0]  mul_y;

   int checks = 0;
   int errors = 0;

   // Shared combinational 2x2 multiplier.
   assign mul_y = {2'b00, mul_a} * {2'b00, mul_b};

   mult_digit_seq #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .mul_a   (mul_a),
      .mul_b   (mul_b),
      .mul_y   (mul_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  va;
      logic [7:0]  vb;
      logic [15:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation: latency, busy span, digit order and result.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp);
      int   n;
      int   nbusy;
      bit   dig_ok;
      logic [1:0] ea;
      logic [1:0] eb;
      a = ta;
      b = tb_v;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = ~ta;
      b = ~tb_v;
      n = 0;
      nbusy = 0;
      dig_ok = 1'b1;
      while (!done && n < 40) begin
         if (busy) nbusy++;
         if (n < 16) begin
            ea = ta[2*(n/4) +: 2];
            eb = tb_v[2*(n%4) +: 2];
            if (mul_a !== ea || mul_b !== eb) dig_ok = 1'b0;
         end
         tick();
         n++;
      end
      check("latency", 32'(n), 32'd16);
      check("busy_cycles", 32'(nbusy), 32'd16);
      check("digit_order", {31'd0, dig_ok}, 32'd1);
      check("product", {16'd0, product}, {16'd0, exp});
      check("busy_after_done", {31'd0, busy}, 32'd0);
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("product_hold", {16'd0, product}, {16'd0, exp});
   endtask

   initial begin
      vec_t vecs[7];
      int   n;
      int   ndone;
      int   t1;
      int   t2;

      vecs[0] = '{8'h03, 8'h01, 16'h0003};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[2] = '{8'hA5, 8'h3C, 16'h26AC};
      vecs[3] = '{8'hE4, 8'h1B, 16'h180C};
      vecs[4] = '{8'h07, 8'h09, 16'h003F};
      vecs[5] = '{8'h10, 8'h10, 16'h0100};
      vecs[6] = '{8'h02, 8'h03, 16'h0006};

      rst_n = 1'b0;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      repeat (2) tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_product", {16'd0, product}, 32'd0);
      check("rst_mul_a", {30'd0, mul_a}, 32'd0);
      check("rst_mul_b", {30'd0, mul_b}, 32'd0);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 7; k++) begin
         run_op(vecs[k].va, vecs[k].vb, vecs[k].exp);
      end

      // start pulse during RUN is ignored.
      a = 8'hA5;
      b = 8'h3C;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      ndone = 0;
      while (n < 40) begin
         if (n == 5) begin
            a = 8'h11;
            b = 8'h22;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            check("ignore_product", {16'd0, product}, 32'h26AC);
            check("ignore_latency", 32'(n), 32'd16);
         end
         tick();
         n++;
      end
      check("ignore_done_count", 32'(ndone), 32'd1);

      // Back-to-back with start held high.
      a = 8'h07;
      b = 8'h09;
      start = 1'b1;
      tick();
      a = 8'h10;
      b = 8'h10;
      n = 0;
      t1 = -1;
      t2 = -1;
      while (n < 60 && t2 < 0) begin
         if (done) begin
            if (t1 < 0) begin
               t1 = n;
               check("b2b_first", {16'd0, product}, 32'h003F);
            end else begin
               t2 = n;
               start = 1'b0;
               check("b2b_second", {16'd0, product}, 32'h0100);
            end
         end
         if (t2 < 0) begin
            tick();
            n++;
         end
      end
      start = 1'b0;
      check("b2b_first_latency", 32'(t1), 32'd16);
      check("b2b_spacing", 32'(t2 - t1), 32'd17);
      repeat (3) tick();

      // Reset mid-RUN aborts the operation.
      a = 8'hFF;
      b = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_product", {16'd0, product}, 32'd0);
      check("abort_mul_a", {30'd0, mul_a}, 32'd0);
      check("abort_mul_b", {30'd0, mul_b}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      ndone = 0;
      repeat (20) begin
         tick();
         if (done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      run_op(8'h02, 8'h03, 16'h0006);

      // Zero operand.
`ifdef MULT_DIGIT_SEQ_ZERO_SKIP_EN
      a = 8'h00;
      b = 8'h77;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("zskip_done", {31'd0, done}, 32'd1);
      check("zskip_product", {16'd0, product}, 32'd0);
      check("zskip_busy", {31'd0, busy}, 32'd0);
      tick();
      check("zskip_done_clear", {31'd0, done}, 32'd0);
      check("zskip_busy_idle", {31'd0, busy}, 32'd0);
`else
      run_op(8'h00, 8'h77, 16'h0000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_digit_seq.md
# mult_digit_seq

Sequencing controller that computes a WIDTH×WIDTH unsigned product by time-multiplexing one shared, purely combinational 2-bit × 2-bit multiplier (the `two_bit_multiplier` datapath). It splits both operands into 2-bit digits, issues one digit pair per clock to the multiplier, and accumulates the shifted 4-bit partial products. The block sits between a requesting master (start/done handshake) and the single 2×2 multiplier instance, which it owns exclusively.

## Interface
- `WIDTH`, default 8: operand width in bits; must be even and ≥ 2. D = WIDTH/2 digits per operand.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  WIDTH: multiplicand, sampled on the accepting edge.
- `b`  in  WIDTH: multiplier, sampled on the accepting edge.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle completion pulse.
- `product`  out  2·WIDTH: result register; holds the last result until the next completion.
- `mul_a`  out  2: digit driven to the shared multiplier A input.
- `mul_b`  out  2: digit driven to the shared multiplier B input.
- `mul_y`  in  4: multiplier result; combinational from `mul_a`/`mul_b` in the same cycle.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `start`=1 at an edge → latch `a`,`b` into operand registers, clear the 2·WIDTH accumulator, set digit counters i=0, j=0, go to RUN.
  - `start`=0 → stay.
- RUN: each cycle drive `mul_a` = a_reg[2i+1:2i] and `mul_b` = b_reg[2j+1:2j].
  - At the edge, acc ← acc + (zero-extended `mul_y` << 2·(i+j)).
  - j is the inner counter (0..D-1) and i the outer (0..D-1), so order is (0,0),(0,1)…(0,D-1),(1,0)…
  - At the edge where i=D-1 and j=D-1: `product` ← final sum (acc + last term), `done` ← 1, state ← IDLE.
- IDLE drives `mul_a`=`mul_b`=0.
- Arithmetic: unsigned; 2·WIDTH-bit accumulator; no overflow is possible since the max product (2^WIDTH−1)² fits. Partial-product shift is truncated to 2·WIDTH bits.
- `start` while in RUN is ignored; there is no queueing and no abort.
- `a`/`b` changes after acceptance have no effect.
- Counters i and j are independent, so non-power-of-two D is supported.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, `mul_a`=`mul_b`=0, accumulator and counters 0.
- Accepting edge E0 → `busy`=1 from E0 through edge E0+D·D.
- Result edge is E0+D·D: `product` is valid and `done`=1 for exactly one cycle after it; `busy`=0 after it. For WIDTH=8 the latency is 16 cycles.
- Back-to-back: `start` high in the cycle where `done`=1 is accepted at the next edge, since state is IDLE. Throughput is one result per D·D+1 cycles maximum.
- `done` deasserts on the next edge regardless of `start`.
- `mul_a`/`mul_b` are driven from registers only (glitch-free per cycle). The `mul_y` → accumulator path is one combinational cycle.
- `rst_n` low mid-RUN → immediate return to reset values. The partial result is discarded, `product` is cleared to 0, and no `done` is issued.

## Configuration
- Macro `MULT_DIGIT_SEQ_ZERO_SKIP_EN`.
- Defined: on acceptance, if `a`==0 or `b`==0, RUN is skipped. At the accepting edge E0, `product` ← 0 and `done` ← 1 (latency 1, `busy` never asserts), and state remains IDLE.
- Undefined: zero operands take the full D·D-cycle RUN path and produce 0.

## Test plan
- WIDTH=8, a=0x03, b=0x01 → `done` exactly 16 cycles after the accepting edge, `product`=0x0003, `busy` high for 16 cycles.
- a=0xFF, b=0xFF → `product`=0xFE01. a=0xA5, b=0x3C → `product`=0x26AC.
- Check that `mul_a`/`mul_b` step through digit pairs in order (0,0),(0,1),(0,2),(0,3),(1,0)…
- Pulse `start` with a=0x11, b=0x22 at cycle 5 of a running 0xA5×0x3C → ignored; `product`=0x26AC, exactly one `done`.
- Hold `start` high continuously, alternating operands 0x07×0x09 then 0x10×0x10 → results 0x003F then 0x0100, with `done` pulses 17 cycles apart.
- Assert `rst_n` low at cycle 8 of 0xFF×0xFF, release, then run 0x02×0x03 → all outputs 0 during reset, no `done` for the aborted op, then `product`=0x0006.
- Run a=0x00, b=0x77:
  - macro defined → `done` on the accepting edge, `product`=0, `busy` stays 0.
  - macro undefined → `done` after 16 cycles, `product`=0.
